// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared types and constants for the M6502 cycle sequencer: FSM state
// encoding, T-state bit indices, T-state ring operations and the decoder
// enables bit index that drives timing_done.
package cpu_cycle_sequencer_pkg;

  // Address of the reset vector low byte; the high byte follows it.
  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'hFFFC;

  // Decoder enables vector: width and the bit that ends an instruction.
  localparam int EN_W            = 16;
  localparam int EN_TIMING_RESET = 0;

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_VEC_LO   = 3'd1,
    ST_VEC_HI   = 3'd2,
    ST_LOAD_PC  = 3'd3,
    ST_RUN      = 3'd4,
    ST_JAM      = 3'd5
  } seq_state_e;

  // Bit positions of each T-state in the one-hot timing vector.
  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
  } tstate_e;

  typedef enum logic [1:0] {
    RING_HOLD    = 2'd0,
    RING_CLEAR   = 2'd1,
    RING_LOAD_T0 = 2'd2,
    RING_ADVANCE = 2'd3
  } ring_op_e;

  // Extracts the timing-reset enable from the decoder enables vector;
  // the integration level feeds this into timing_done.
  function automatic logic timing_reset_en(input logic [EN_W-1:0] enables);
    return enables[EN_TIMING_RESET];
  endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_t_state_ring.sv
// 8-bit one-hot T-state ring: clear, load T0, advance one T-state or hold.
// overflow_o flags that the ring sits on T7 and cannot advance further.
module cpu_cycle_sequencer_t_state_ring
  import cpu_cycle_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  ring_op_e   op_i,
  output logic [7:0] ring_o,
  output logic       overflow_o
);

  logic [7:0] ring_q;
  logic [7:0] ring_d;

  // Next ring value for the requested operation.
  always_comb begin
    ring_d = ring_q;
    case (op_i)
      RING_CLEAR:   ring_d = 8'h00;
      RING_LOAD_T0: ring_d = 8'h01;
      RING_ADVANCE: ring_d = {ring_q[6:0], 1'b0};
      default:      ring_d = ring_q;
    endcase
  end

  // Ring register; en_i low freezes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ring_q <= 8'h00;
    end else if (en_i) begin
      ring_q <= ring_d;
    end
  end

  assign ring_o     = ring_q;
  assign overflow_o = ring_q[T7];

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Cycle-level controller for the M6502 core: runs the reset vector fetch,
// then sequences T-states per instruction until the decoder signals the
// last cycle, latching the opcode in T0. A runaway instruction past T7
// parks the sequencer in JAM until reset. rdy low freezes everything.
module cpu_cycle_sequencer
  import cpu_cycle_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR       = RESET_VECTOR_DEFAULT,
  parameter int          RESET_DUMMY_CYCLES = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rdy,
  input  logic [7:0]  data_in,
  input  logic        timing_done,
  output logic [7:0]  timing,
  output logic [7:0]  opcode,
  output logic        sync,
  output logic        decode_reset,
  output logic        vec_addr_en,
  output logic [15:0] vec_addr,
  output logic        pc_load,
  output logic [15:0] pc_load_value,
  output logic        jam
);

  localparam logic [3:0]  CNT_LAST    = 4'(RESET_DUMMY_CYCLES - 1);
  localparam logic [15:0] VEC_HI_ADDR = RESET_VECTOR + 16'd1;

  seq_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] vec_lo_q, vec_lo_d;
  logic [7:0] vec_hi_q, vec_hi_d;
  logic [7:0] opcode_q, opcode_d;
  ring_op_e   ring_op;
  logic [7:0] timing_w;
  logic       t_overflow;

  cpu_cycle_sequencer_t_state_ring u_ring (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .en_i       (rdy),
    .op_i       (ring_op),
    .ring_o     (timing_w),
    .overflow_o (t_overflow)
  );

  // Next-state, latch enables, ring control and decoded outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_lo_d    = vec_lo_q;
    vec_hi_d    = vec_hi_q;
    opcode_d    = opcode_q;
    ring_op     = RING_HOLD;
    vec_addr_en = 1'b0;
    vec_addr    = RESET_VECTOR;
    pc_load     = 1'b0;
    sync        = 1'b0;
    case (state_q)
      ST_RST_WAIT: begin
        ring_op = RING_CLEAR;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = ST_VEC_LO;
      end
      ST_VEC_LO: begin
        ring_op     = RING_CLEAR;
        vec_addr_en = 1'b1;
        vec_addr    = RESET_VECTOR;
        vec_lo_d    = data_in;
        state_d     = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        ring_op     = RING_CLEAR;
        vec_addr_en = 1'b1;
        vec_addr    = VEC_HI_ADDR;
        vec_hi_d    = data_in;
        state_d     = ST_LOAD_PC;
      end
      ST_LOAD_PC: begin
        pc_load = 1'b1;
        ring_op = RING_LOAD_T0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (timing_w[T0]) begin
          // Decoder still holds the previous opcode here, so timing_done
          // is meaningless in T0 and the new opcode is captured instead.
          sync     = 1'b1;
          opcode_d = data_in;
          ring_op  = RING_ADVANCE;
        end else if (timing_done) begin
          ring_op = RING_LOAD_T0;
        end else if (!t_overflow) begin
          ring_op = RING_ADVANCE;
        end else begin
          state_d = ST_JAM;
        end
      end
      ST_JAM: begin
        ring_op = RING_HOLD;
      end
      default: begin
        state_d = ST_RST_WAIT;
      end
    endcase
  end

  // State, counter, vector bytes and opcode; rdy low holds all of them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RST_WAIT;
      cnt_q    <= 4'd0;
      vec_lo_q <= 8'h00;
      vec_hi_q <= 8'h00;
      opcode_q <= 8'hEA;
    end else if (rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vec_lo_q <= vec_lo_d;
      vec_hi_q <= vec_hi_d;
      opcode_q <= opcode_d;
    end
  end

  assign timing        = timing_w;
  assign opcode        = opcode_q;
  assign decode_reset  = (state_q != ST_RUN);
  assign jam           = (state_q == ST_JAM);
  assign pc_load_value = {vec_hi_q, vec_lo_q};

endmodule

// File: doc/cpu_cycle_sequencer.md
Name: cpu_cycle_sequencer

Overview:
Cycle-level controller for the M6502 core. It owns the T-state one-hot `timing` vector and the opcode register that feed the instruction decoder. It runs the power-on/reset vector fetch, then sequences fetch/execute cycles, ending each instruction when the decoder asserts its timing-reset enable. It also stalls on RDY and traps runaway instructions in a jam state.

Parameters:
RESET_VECTOR, 16'hFFFC, address of reset vector low byte; the high byte is at RESET_VECTOR+1.
RESET_DUMMY_CYCLES, 5, idle cycles between reset release and the vector read (range 1..15).

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
rdy  input  1  1 = advance; 0 = freeze all state
data_in  input  8  memory read data bus
timing_done  input  1  decoder enables[TIMING_RESET]: current cycle is the last of the instruction
timing  output  8  one-hot T-state to decoder; bit0 = T0 fetch cycle
opcode  output  8  latched opcode to decoder
sync  output  1  high during opcode fetch cycle (T0 in RUN)
decode_reset  output  1  to decoder reset input; high whenever state != RUN
vec_addr_en  output  1  address mux selects vec_addr instead of PC
vec_addr  output  16  vector address being read
pc_load  output  1  one-cycle request to load PC from pc_load_value
pc_load_value  output  16  {vec_hi, vec_lo}
jam  output  1  sticky fault: instruction exceeded T7

Behaviour:
- States: RST_WAIT, VEC_LO, VEC_HI, LOAD_PC, RUN, JAM.
- While reset_n=0 (asynchronous):
  - state=RST_WAIT, dummy counter=0, timing=8'h00, opcode=8'hEA, vec regs=0.
  - sync=0, vec_addr_en=0, pc_load=0, jam=0, decode_reset=1.
- RST_WAIT: counter increments each rdy cycle; on counter==RESET_DUMMY_CYCLES-1, go to VEC_LO.
- VEC_LO: vec_addr_en=1, vec_addr=RESET_VECTOR; latch data_in into vec_lo at the edge; go to VEC_HI.
- VEC_HI: vec_addr_en=1, vec_addr=RESET_VECTOR+1; latch data_in into vec_hi; go to LOAD_PC.
- LOAD_PC: pc_load=1, pc_load_value={vec_hi,vec_lo}; next state RUN with timing=8'h01.
- Reset sequence timing: first sync is exactly RESET_DUMMY_CYCLES+3 rdy cycles after reset release.
- RUN, T0 (timing[0]): sync=1; latch opcode<=data_in at the edge; next timing=8'h02.
  - timing_done is ignored in T0, because the decoder still sees the previous opcode.
- RUN, Tn with n>=1:
  - timing_done=1 -> next timing=8'h01.
  - else if n<7 -> next timing shifts left by 1.
  - else (T7 and no done) -> JAM.
- JAM: timing=8'h80 held, jam=1, sync=0, decode_reset=1.
  - Only reset_n exits JAM.
- rdy=0: every register holds, in every state including the reset sequence. Outputs stay stable; pc_load stays high if stalled in LOAD_PC, so the PC load must be idempotent.
- `timing` is always one-hot in RUN/JAM and zero outside them. pc_load_value is valid only while pc_load=1, and holds its value otherwise.
- reset_n asserted mid-instruction or mid-vector: immediate return to reset values. Any partially latched vector byte is discarded.
- vec_addr wraps modulo 2^16 (RESET_VECTOR=16'hFFFF gives high-byte address 16'h0000).

Decomposition:
- Shared package/defines file: state encodings, T-state bit indices (T0..T7), default RESET_VECTOR, and the existing enables bit-index defines, reused for the timing_done hookup.
- One natural sub-module: t_state_ring, an 8-bit one-hot shift register with load-T0, advance, hold and overflow flag.
- The FSM, vector latch and opcode register stay in cpu_cycle_sequencer.

Test Plan:
- Reset vector: release reset_n with rdy=1, memory[FFFC]=8'h00, [FFFD]=8'h80 -> vec_addr FFFC then FFFD, pc_load=1 with 16'h8000 in cycle 8, sync=1 with timing=8'h01 in cycle 9.
- Immediate instruction: T0 data_in=8'hA9, timing_done asserted in T1 -> opcode=8'hA9, timing sequence 01,02,01; sync high only in T0.
- JMP length: opcode 8'h4C, timing_done asserted in T2 only -> timing 01,02,04,01.
- RDY stall: drop rdy for 3 cycles in VEC_HI, then for 2 cycles in T1 -> all outputs frozen, sequence otherwise identical, cycle count +5.
- Jam: opcode latched, timing_done never asserted -> timing reaches 8'h80, then jam=1 and decode_reset=1 held; reset_n pulse clears jam and restarts the vector fetch.
- Mid-op reset: assert reset_n low asynchronously during T2 -> timing=0 and opcode=8'hEA immediately, without waiting for a clock edge; the vector sequence replays after release.
